// File: rtl/dsp_mem_write_dist.sv
// dsp_mem_write_dist: buffers write requests in a small FIFO and issues them in
// push order to a bank of DSP units. Each write goes to one unit or is broadcast
// to all units. The head of the FIFO waits until every unit it targets is free.
// Optional issue and stall counters are enabled by defining DSP_WRITE_STATS_EN.
module dsp_mem_write_dist #(
  parameter int DATA_WIDTH      = 32,
  parameter int N_DSP_UNIT      = 8,
  parameter int UNIT_ADDR_WIDTH = 13,
  parameter int FIFO_DEPTH      = 4,
  localparam int LOG_N          = (N_DSP_UNIT > 1) ? $clog2(N_DSP_UNIT) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [UNIT_ADDR_WIDTH+LOG_N-1:0] in_addr,
  input  logic                             in_bcast,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_DSP_UNIT-1:0]            unit_busy,
  output logic [UNIT_ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [N_DSP_UNIT-1:0]            out_en,
  output logic                             err_unmapped,
  output logic [31:0]                      wr_count,
  output logic [31:0]                      stall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LOG_N:0] N_UNITS = (LOG_N + 1)'(N_DSP_UNIT);

  // Entry storage; an entry carries its precomputed target mask
  logic [N_DSP_UNIT-1:0]      mask_mem [FIFO_DEPTH];
  logic [UNIT_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      data_mem [FIFO_DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable
  logic [PTR_W:0]             wptr_q, wptr_d;
  logic [PTR_W:0]             rptr_q, rptr_d;
  logic                       ready_q, ready_d;
  logic [N_DSP_UNIT-1:0]      out_en_q;
  logic [UNIT_ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0]      out_data_q;
  logic                       err_q;

  logic [LOG_N-1:0]           unit_sel;
  logic [N_DSP_UNIT-1:0]      sel_onehot;
  logic [N_DSP_UNIT-1:0]      push_mask;
  logic [N_DSP_UNIT-1:0]      head_mask;
  logic                       sel_mapped;
  logic                       accept;
  logic                       push;
  logic                       drop;
  logic                       fifo_empty;
  logic                       issue;

  assign unit_sel = in_addr[UNIT_ADDR_WIDTH +: LOG_N];

  generate
    for (genvar gi = 0; gi < N_DSP_UNIT; gi++) begin : g_onehot
      assign sel_onehot[gi] = (unit_sel == LOG_N'(gi));
    end
  endgenerate

  // A select beyond the populated units is only legal as part of a broadcast
  assign sel_mapped = in_bcast || ({1'b0, unit_sel} < N_UNITS);
  assign push_mask  = in_bcast ? {N_DSP_UNIT{1'b1}} : sel_onehot;
  assign accept     = in_valid && ready_q;
  assign push       = accept && sel_mapped;
  assign drop       = accept && !sel_mapped;

  assign fifo_empty = (wptr_q == rptr_q);
  assign head_mask  = mask_mem[rptr_q[PTR_W-1:0]];
  assign issue      = !fifo_empty && ((head_mask & unit_busy) == '0);

  assign wptr_d  = wptr_q + {{PTR_W{1'b0}}, push};
  assign rptr_d  = rptr_q + {{PTR_W{1'b0}}, issue};
  // Ready is registered from the next occupancy, so a pop while full
  // does not open the input in the same cycle
  assign ready_d = !((wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]) &&
                     (wptr_d[PTR_W] != rptr_d[PTR_W]));

  // Pointer, handshake and issue-register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ready_q    <= 1'b0;
      out_en_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ready_q  <= ready_d;
      err_q    <= drop;
      out_en_q <= issue ? head_mask : '0;
      if (issue) begin
        out_addr_q <= addr_mem[rptr_q[PTR_W-1:0]];
        out_data_q <= data_mem[rptr_q[PTR_W-1:0]];
      end
    end
  end

  // Entry write on push; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wptr_q[PTR_W-1:0]] <= push_mask;
      addr_mem[wptr_q[PTR_W-1:0]] <= in_addr[UNIT_ADDR_WIDTH-1:0];
      data_mem[wptr_q[PTR_W-1:0]] <= in_data;
    end
  end

  assign in_ready     = ready_q;
  assign out_en       = out_en_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign err_unmapped = err_q;

`ifdef DSP_WRITE_STATS_EN
  logic [31:0] wr_count_q;
  logic [31:0] stall_count_q;
  logic        head_blocked;

  assign head_blocked = !fifo_empty && !issue;

  // Issue and blocked-head counters, wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_q + 32'(issue);
      stall_count_q <= stall_count_q + 32'(head_blocked);
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`else
  assign wr_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_dsp_mem_write_dist.sv
// Testbench for dsp_mem_write_dist: an 8-unit and a 6-unit instance share one
// input stream and are each compared every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_dsp_mem_write_dist;

  localparam int DEPTH = 4;
`ifdef DSP_WRITE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_addr;
  logic        in_bcast;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  busy;

  logic        rdy8, err8;
  logic [12:0] oaddr8;
  logic [31:0] odata8, wr8, st8;
  logic [7:0]  en8;
  logic        rdy6, err6;
  logic [12:0] oaddr6;
  logic [31:0] odata6, wr6, st6;
  logic [5:0]  en6;

  always #5 clk = ~clk;

  dsp_mem_write_dist #(.DATA_WIDTH(32), .N_DSP_UNIT(8), .UNIT_ADDR_WIDTH(13), .FIFO_DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .reset(rst_n), .in_addr(in_addr), .in_bcast(in_bcast), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy8), .unit_busy(busy), .out_addr(oaddr8), .out_data(odata8),
    .out_en(en8), .err_unmapped(err8), .wr_count(wr8), .stall_count(st8));

  dsp_mem_write_dist #(.DATA_WIDTH(32), .N_DSP_UNIT(6), .UNIT_ADDR_WIDTH(13), .FIFO_DEPTH(DEPTH)) u_dut6 (
    .clk(clk), .reset(rst_n), .in_addr(in_addr), .in_bcast(in_bcast), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy6), .unit_busy(busy[5:0]), .out_addr(oaddr6), .out_data(odata6),
    .out_en(en6), .err_unmapped(err6), .wr_count(wr6), .stall_count(st6));

  // Reference model: a plain list of pending writes per instance
  typedef struct {
    logic [7:0]  mask;
    logic [12:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq [2][16];
  int          mlen [2];
  logic [7:0]  e_en [2];
  logic [12:0] e_addr [2];
  logic [31:0] e_data [2];
  logic        e_err [2];
  logic        e_rdy [2];
  int unsigned e_wr [2];
  int unsigned e_st [2];

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mlen[u]   = 0;
      e_en[u]   = 8'h00;
      e_addr[u] = 13'h0;
      e_data[u] = 32'h0;
      e_err[u]  = 1'b0;
      e_rdy[u]  = 1'b0;
      e_wr[u]   = 0;
      e_st[u]   = 0;
    end
  endtask

  // One clock edge of the model: issue the oldest write if its targets are free,
  // then accept the new request if the buffer had room before the edge
  task automatic model_step(input int u);
    int         n;
    int         sel;
    logic [7:0] all_m;
    logic [7:0] bz;
    logic [7:0] m;
    bit         iss;
    bit         rdy;
    ent_t       e;
    n     = (u == 0) ? 8 : 6;
    all_m = (u == 0) ? 8'hFF : 8'h3F;
    bz    = (u == 0) ? busy : {2'b00, busy[5:0]};
    rdy   = e_rdy[u];
    iss   = (mlen[u] > 0) && ((mq[u][0].mask & bz) == 8'h00);
    if (mlen[u] > 0 && !iss) e_st[u]++;
    if (iss) begin
      e_en[u]   = mq[u][0].mask;
      e_addr[u] = mq[u][0].addr;
      e_data[u] = mq[u][0].data;
      e_wr[u]++;
      for (int i = 0; i < mlen[u] - 1; i++) mq[u][i] = mq[u][i+1];
      mlen[u]--;
    end else begin
      e_en[u] = 8'h00;
    end
    e_err[u] = 1'b0;
    if (in_valid && rdy) begin
      sel = int'(in_addr[15:13]);
      if (in_bcast) m = all_m;
      else if (sel < n) m = 8'h01 << sel;
      else m = 8'h00;
      if (m == 8'h00) begin
        e_err[u] = 1'b1;
      end else begin
        e.mask = m;
        e.addr = in_addr[12:0];
        e.data = in_data;
        mq[u][mlen[u]] = e;
        mlen[u]++;
      end
    end
    e_rdy[u] = (mlen[u] != DEPTH);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("en8",    32'(en8),    32'(e_en[0]));
      check_eq("addr8",  32'(oaddr8), 32'(e_addr[0]));
      check_eq("data8",  odata8,      e_data[0]);
      check_eq("err8",   32'(err8),   32'(e_err[0]));
      check_eq("rdy8",   32'(rdy8),   32'(e_rdy[0]));
      check_eq("wr8",    wr8,         STATS ? e_wr[0] : 32'd0);
      check_eq("stall8", st8,         STATS ? e_st[0] : 32'd0);
      check_eq("en6",    32'(en6),    32'(e_en[1][5:0]));
      check_eq("addr6",  32'(oaddr6), 32'(e_addr[1]));
      check_eq("data6",  odata6,      e_data[1]);
      check_eq("err6",   32'(err6),   32'(e_err[1]));
      check_eq("rdy6",   32'(rdy6),   32'(e_rdy[1]));
      check_eq("wr6",    wr6,         STATS ? e_wr[1] : 32'd0);
      check_eq("stall6", st6,         STATS ? e_st[1] : 32'd0);
      if (en8 != 8'h00) $display("issue n8 en=%h addr=%h data=%h", en8, oaddr8, odata8);
      if (en6 != 6'h00) $display("issue n6 en=%h addr=%h data=%h", en6, oaddr6, odata6);
    end
  end

  // Drive one cycle of inputs, then wait for the following falling edge
  task automatic cyc(input logic v, input logic b, input logic [15:0] a, input logic [31:0] d,
                     input logic [7:0] bz);
    in_valid = v;
    in_bcast = b;
    in_addr  = a;
    in_data  = d;
    busy     = bz;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bcast = 1'b0; in_addr = '0; in_data = '0; busy = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_en8",  32'(en8),    32'h0);
    check_eq("rst_rdy8", 32'(rdy8),   32'h0);
    check_eq("rst_data8", odata8,     32'h0);
    check_eq("rst_wr8",  wr8,         32'h0);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("rdy_after_rst", 32'(rdy8), 32'h1);

    // Single write to unit 5, two-cycle latency, one-cycle enable
    cyc(1'b1, 1'b0, {3'd5, 13'h0042}, 32'hDEADBEEF, 8'h00);
    check_eq("lat_early_en8", 32'(en8), 32'h0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("single_en8",   32'(en8),    32'h20);
    check_eq("single_addr8", 32'(oaddr8), 32'h0042);
    check_eq("single_data8", odata8,      32'hDEADBEEF);
    check_eq("single_en6",   32'(en6),    32'h20);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("single_off_en8",  32'(en8),    32'h0);
    check_eq("single_hold_a8",  32'(oaddr8), 32'h0042);

    // Broadcast held by one busy unit for three cycles
    cyc(1'b1, 1'b1, 16'h0, 32'h1, 8'h04);
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h04);
    check_eq("bc_wait_en8", 32'(en8), 32'h0);
    check_eq("bc_stall8",   st8, STATS ? 32'd3 : 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("bc_en8",   32'(en8), 32'hFF);
    check_eq("bc_en6",   32'(en6), 32'h3F);
    check_eq("bc_data8", odata8,   32'h1);
    check_eq("bc_wr8",   wr8, STATS ? 32'd2 : 32'd0);

    // Unit select 7: valid for 8 units, dropped for 6 units
    cyc(1'b1, 1'b0, {3'd7, 13'h0010}, 32'h77, 8'h00);
    check_eq("unm_err6", 32'(err6), 32'h1);
    check_eq("unm_err8", 32'(err8), 32'h0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("unm_err6_off", 32'(err6), 32'h0);
    check_eq("unm_en6",      32'(en6),  32'h0);
    check_eq("unm_en8",      32'(en8),  32'h80);
    check_eq("unm_wr6",      wr6, STATS ? 32'd2 : 32'd0);

    // Fill while every unit is busy, then drain in order
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, {3'(i % 6), 13'(i)}, 32'(100 + i), 8'hFF);
      if (i == 3) begin
        check_eq("full_rdy8", 32'(rdy8), 32'h0);
        check_eq("full_rdy6", 32'(rdy6), 32'h0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
      check_eq("drain_data8", odata8,   32'(100 + j));
      check_eq("drain_en8",   32'(en8), 32'(8'h01 << j));
    end
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("drain_done_en8", 32'(en8), 32'h0);

    // Reset with three entries still buffered
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, {3'(i), 13'(16'h100 + i)}, 32'(200 + i), 8'hFF);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("pre_rst_en8", 32'(en8), 32'h01);
    busy = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_en8",  32'(en8),  32'h0);
    check_eq("async_rst_rdy8", 32'(rdy8), 32'h0);
    check_eq("async_rst_en6",  32'(en6),  32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
      check_eq("no_stale_en8", 32'(en8), 32'h0);
    end
    cyc(1'b1, 1'b0, {3'd2, 13'h0005}, 32'h55, 8'h00);
    check_eq("post_rst_early", 32'(en8), 32'h0);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);
    check_eq("post_rst_en8",   32'(en8), 32'h04);
    check_eq("post_rst_data8", odata8,   32'h55);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), 16'($urandom),
          $urandom, 8'($urandom & $urandom & $urandom));
    end
    repeat (10) cyc(1'b0, 1'b0, 16'h0, 32'h0, 8'h00);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
